// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the LCD frame sequencer: state encoding,
// the padding character and the display geometry that sets the frame length.
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WRITE,
        GAP,
        DONE
    } seq_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int LCD_LINE_LEN  = 16;
    localparam int LCD_LINES     = 2;
    localparam int LCD_FRAME_LEN = LCD_LINE_LEN * LCD_LINES;

endpackage

// File: rtl/lcd_seq_timer.sv
// Character-period timer for the LCD frame sequencer.
// Loaded on the cycle before a write starts, it counts down from CHAR_GAP-1,
// so the count tells how far into the character period we are.  Three strobes
// come out of it: end of the write-enable hold, the early gap exit that leaves
// room for the next fetch/load, and the full-period end used after the last
// character of a frame.
module lcd_seq_timer #(
    parameter int CHAR_GAP    = 262144,
    parameter int HOLD_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic hold_expired,
    output logic gap_expired,
    output logic gap_end
);

    localparam int W = $clog2(CHAR_GAP);

    localparam logic [W-1:0] START_COUNT = W'(CHAR_GAP - 1);
    localparam logic [W-1:0] HOLD_MARK   = W'(CHAR_GAP - HOLD_CYCLES);
    localparam logic [W-1:0] GAP_MARK    = W'(2);

    logic [W-1:0] count;

    // Down-counter: reload at the start of each character, park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= START_COUNT;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign hold_expired = (count == HOLD_MARK);
    assign gap_expired  = (count == GAP_MARK);
    assign gap_end      = (count == '0);

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Streams one 2x16 frame from the message ROM into the 4-bit LCD driver,
// one character every CHAR_GAP cycles with write_en held HOLD_CYCLES cycles.
// Optional feature macro: LCD_SEQ_NUL_PAD_EN -- a 0x00 byte ends the text and
// the rest of the frame is padded with spaces without further ROM reads.
module lcd_frame_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int CHAR_GAP    = 262144,
    parameter int HOLD_CYCLES = 65536,
    parameter int FRAME_LEN   = LCD_FRAME_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh_req,
    input  logic [2:0] msg_sel,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] lcd_data,
    output logic       lcd_write_en,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

    seq_state_t state;
    seq_state_t state_next;

    logic [2:0] msg_lat;
    logic [4:0] char_idx;
    logic       pending;
    logic       start_frame;
    logic       advance;
    logic       timer_load;
    logic       hold_expired;
    logic       gap_expired;
    logic       gap_end;
    logic [7:0] load_byte;

    lcd_seq_timer #(
        .CHAR_GAP    (CHAR_GAP),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load         (timer_load),
        .hold_expired (hold_expired),
        .gap_expired  (gap_expired),
        .gap_end      (gap_end)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; non-final gaps end two cycles early so FETCH and LOAD
    // complete the period, while the final gap runs the full period before DONE.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        advance     = 1'b0;
        timer_load  = 1'b0;
        case (state)
            IDLE: begin
                if (refresh_req) begin
                    state_next  = FETCH;
                    start_frame = 1'b1;
                end
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                state_next = WRITE;
                timer_load = 1'b1;
            end
            WRITE: begin
                if (hold_expired) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (char_idx == LAST_IDX) begin
                    if (gap_end) begin
                        state_next = DONE;
                    end
                end else if (gap_expired) begin
                    state_next = FETCH;
                    advance    = 1'b1;
                end
            end
            DONE: begin
                if (pending || refresh_req) begin
                    state_next  = FETCH;
                    start_frame = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One-deep request memory: any request during a frame queues one more frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (state == DONE) begin
            pending <= 1'b0;
        end else if (refresh_req && (state != IDLE)) begin
            pending <= 1'b1;
        end
    end

    // Message latch and character index; msg_sel is only looked at on frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_lat  <= '0;
            char_idx <= '0;
        end else if (start_frame) begin
            msg_lat  <= msg_sel;
            char_idx <= '0;
        end else if (advance) begin
            char_idx <= char_idx + 5'd1;
        end
    end

`ifdef LCD_SEQ_NUL_PAD_EN
    logic       nul_seen;
    logic [4:0] rom_idx;

    // After a NUL the ROM address freezes and every later character is a space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nul_seen <= 1'b0;
            rom_idx  <= '0;
        end else if (start_frame) begin
            nul_seen <= 1'b0;
            rom_idx  <= '0;
        end else begin
            if ((state == LOAD) && (rom_data == 8'h00)) begin
                nul_seen <= 1'b1;
            end
            if (advance && !nul_seen) begin
                rom_idx <= rom_idx + 5'd1;
            end
        end
    end

    assign load_byte = (nul_seen || (rom_data == 8'h00)) ? ASCII_SPACE : rom_data;
    assign rom_addr  = {msg_lat, rom_idx};
`else
    assign load_byte = rom_data;
    assign rom_addr  = {msg_lat, char_idx};
`endif

    // Character register; holds its byte for the whole character period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_data <= '0;
        end else if (state == LOAD) begin
            lcd_data <= load_byte;
        end
    end

    assign lcd_write_en = (state == WRITE);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule
